// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM stage: access FSM encodings and pipeline register layouts.
package mem_stage_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEFAULT  = 16;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        zero;
    logic [4:0]  reg_addr;
    logic [31:0] alu_res;
    logic [31:0] rt_data;
    logic [31:0] branch_addr;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  reg_addr;
    logic [31:0] alu_res;
    logic [31:0] rdata;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_dmem_access_fsm.sv
// Data-memory handshake tracker: raises stall while a request waits for ack and
// aborts the access once the wait budget is spent.
//
// state    | meaning
// MEM_IDLE | no access outstanding; a request acked in the same cycle completes here
// MEM_WAIT | request issued, waiting for ack; remain_q counts down to the abort cycle
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic stall,
  output logic timeout
);

  localparam int unsigned   CW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Entering WAIT already accounts for the IDLE cycle, so TIMEOUT-2 waits remain.
  localparam logic [CW-1:0] REMAIN_LOAD = CW'(TIMEOUT - 2);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] remain_q, remain_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MEM_IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      MEM_IDLE: begin
        if (req && !ack) begin
          state_d  = MEM_WAIT;
          remain_d = REMAIN_LOAD;
        end
      end
      MEM_WAIT: begin
        if (!req || ack || (remain_q == '0)) begin
          state_d  = MEM_IDLE;
          remain_d = '0;
        end else begin
          remain_d = remain_q - 1'b1;
        end
      end
      default: begin
        state_d  = MEM_IDLE;
        remain_d = '0;
      end
    endcase
  end

  always_comb begin
    timeout = (state_q == MEM_WAIT) && req && !ack && (remain_q == '0);
    stall   = req && !ack && !timeout;
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM and MEM/WB pipeline registers with branch resolution, data-memory
// request generation and forwarding taps for the MEM stage.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res_ex,
  input  logic [31:0] RtData_ex,
  input  logic [4:0]  RegWriteAddr_ex,
  input  logic [31:0] Branch_addr_ex,
  input  logic        alu_zero_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        RegWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic        Branch_ex,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall_mem,
  output logic        PCSrc_mem,
  output logic [31:0] Branch_addr_mem,
  output logic        flush_mem,
  output logic        RegWrite_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic [31:0] alu_res_mem,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic [4:0]  RegWriteAddr_wb,
  output logic [31:0] alu_res_wb,
  output logic [31:0] mem_rdata_wb,
  output logic        mem_err
);

  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    mem_err_q, mem_err_d;
  logic    pc_src, req, stall, timeout;

  dmem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (dmem_ack),
    .stall   (stall),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_q  <= '0;
      mem_wb_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      ex_mem_q  <= ex_mem_d;
      mem_wb_q  <= mem_wb_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    pc_src = ex_mem_q.valid && ex_mem_q.branch && ex_mem_q.zero;
    req    = ex_mem_q.valid && (ex_mem_q.mem_read || ex_mem_q.mem_write);
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall) begin
      ex_mem_d.valid       = 1'b1;
      ex_mem_d.mem_read    = MemRead_ex;
      ex_mem_d.mem_write   = MemWrite_ex;
      ex_mem_d.reg_write   = RegWrite_ex;
      ex_mem_d.mem_to_reg  = MemtoReg_ex;
      ex_mem_d.branch      = Branch_ex;
      ex_mem_d.zero        = alu_zero_ex;
      ex_mem_d.reg_addr    = RegWriteAddr_ex;
      ex_mem_d.alu_res     = alu_res_ex;
      ex_mem_d.rt_data     = RtData_ex;
      ex_mem_d.branch_addr = Branch_addr_ex;
      // Taken branch squashes the instruction behind it as it enters MEM.
      if (pc_src) begin
        ex_mem_d.valid      = 1'b0;
        ex_mem_d.mem_read   = 1'b0;
        ex_mem_d.mem_write  = 1'b0;
        ex_mem_d.reg_write  = 1'b0;
        ex_mem_d.mem_to_reg = 1'b0;
        ex_mem_d.branch     = 1'b0;
        ex_mem_d.zero       = 1'b0;
      end
    end
  end

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (stall) begin
      mem_wb_d.reg_write  = 1'b0;
      mem_wb_d.mem_to_reg = 1'b0;
    end else begin
      mem_wb_d.reg_write  = ex_mem_q.valid && ex_mem_q.reg_write && !timeout;
      mem_wb_d.mem_to_reg = ex_mem_q.valid && ex_mem_q.mem_to_reg;
      mem_wb_d.reg_addr   = ex_mem_q.reg_addr;
      mem_wb_d.alu_res    = ex_mem_q.alu_res;
      mem_wb_d.rdata      = timeout ? ERR_DATA : dmem_rdata;
    end
    mem_err_d = mem_err_q || timeout;
  end

  always_comb begin
    dmem_req         = req;
    dmem_we          = ex_mem_q.valid && ex_mem_q.mem_write;
    dmem_addr        = ex_mem_q.alu_res;
    dmem_wdata       = ex_mem_q.rt_data;
    stall_mem        = stall;
    PCSrc_mem        = pc_src;
    flush_mem        = pc_src;
    Branch_addr_mem  = ex_mem_q.branch_addr;
    RegWrite_mem     = ex_mem_q.valid && ex_mem_q.reg_write;
    RegWriteAddr_mem = ex_mem_q.valid ? ex_mem_q.reg_addr : 5'd0;
    alu_res_mem      = ex_mem_q.valid ? ex_mem_q.alu_res : 32'd0;
    RegWrite_wb      = mem_wb_q.reg_write;
    MemtoReg_wb      = mem_wb_q.mem_to_reg;
    RegWriteAddr_wb  = mem_wb_q.reg_addr;
    alu_res_wb       = mem_wb_q.alu_res;
    mem_rdata_wb     = mem_wb_q.rdata;
    mem_err          = mem_err_q;
  end

endmodule
